// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction ROM combinationally,
// and fills the IF/ID pipeline register. Handles decode stalls, branch/jump
// redirects and stops fetching on the ROM halt word.
module instr_fetch_unit #(
  parameter int          ADDR_W    = 5,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_instr,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        if_valid_nxt;
  logic [31:0] if_pc_nxt;
  logic [31:0] if_instr_nxt;
  logic [31:0] fetch_count_nxt;
  logic        out_of_range;
  logic [31:0] eff;

  // The ROM is word addressed; any PC bits above its depth are simply dropped here.
  assign rom_addr = pc[ADDR_W+1:2];

  // A PC beyond the ROM behaves as if it read the halt word.
  assign out_of_range = (pc[31:ADDR_W+2] != '0);
  assign eff          = out_of_range ? HALT_WORD : rom_instr;

  assign halted = (state == HALTED);

  // Next-state and IF/ID register update; priority is redirect > stall > normal fetch.
  always_comb begin
    // NOTE: every signal gets a hold default first, so no branch can leave one unassigned and infer a latch.
    state_nxt       = state;
    pc_nxt          = pc;
    if_valid_nxt    = if_valid;
    if_pc_nxt       = if_pc;
    if_instr_nxt    = if_instr;
    fetch_count_nxt = fetch_count;

    if (redirect_valid) begin
      // Flush: the word fetched this cycle is dropped and a bubble enters IF/ID.
      pc_nxt       = {redirect_pc[31:2], 2'b00};
      state_nxt    = RUN;
      if_valid_nxt = 1'b0;
    end else if (!stall) begin
      unique case (state)
        RUN: begin
          if (eff == HALT_WORD) begin
            // PC parks on the halt address; the halt word itself is never delivered.
            state_nxt    = HALTED;
            if_valid_nxt = 1'b0;
          end else begin
            if_instr_nxt    = eff;
            if_pc_nxt       = pc;
            if_valid_nxt    = 1'b1;
            pc_nxt          = pc + 32'd4;
            fetch_count_nxt = fetch_count + 32'd1;
          end
        end
        HALTED: begin
          if_valid_nxt = 1'b0;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= 32'h0000_0000;
      if_instr    <= NOP;
      fetch_count <= 32'h0000_0000;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      if_valid    <= if_valid_nxt;
      if_pc       <= if_pc_nxt;
      if_instr    <= if_instr_nxt;
      fetch_count <= fetch_count_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a behavioural ROM, a scoreboard of
// expected (pc, instr) deliveries, and one task per scenario.
module tb_instr_fetch_unit;

  localparam int          ADDR_W = 5;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] W0     = 32'h0080_0293;
  localparam logic [31:0] W1     = 32'h00F0_0313;
  localparam logic [31:0] W2     = 32'h0062_A023;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_instr;
  logic              stall = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = 32'h0;
  logic              if_valid;
  logic [31:0]       if_pc;
  logic [31:0]       if_instr;
  logic              halted;
  logic [31:0]       fetch_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] rom [2**ADDR_W];

  assign rom_instr = rom[rom_addr];

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0000_0000),
    .HALT_WORD(HALT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_addr      (rom_addr),
    .rom_instr     (rom_instr),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: a fresh delivery is an edge without rst or stall that leaves if_valid high.
  always @(posedge clk) begin
    automatic logic fresh = !rst && !stall && !redirect_valid;
    exp_t e;
    #1;
    if (fresh && if_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_delivery: got pc=%h instr=%h, expected none", if_pc, if_instr);
      end else begin
        e = exp_q.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          bad++;
          $display("FAIL delivery: got pc=%h instr=%h, expected pc=%h instr=%h",
                   if_pc, if_instr, e.pc, e.instr);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    step(2);
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== NOP) begin
      bad++;
      $display("FAIL reset_ifid: got v=%b pc=%h instr=%h, expected 0/0/%h", if_valid, if_pc, if_instr, NOP);
    end
    total++;
    if (halted !== 1'b0 || fetch_count !== 32'h0 || rom_addr !== '0) begin
      bad++;
      $display("FAIL reset_state: got halted=%b cnt=%0d addr=%0d, expected 0/0/0", halted, fetch_count, rom_addr);
    end
  endtask

  task automatic test_straight_line();
    do_reset();
    push(32'd0, W0);
    push(32'd4, W1);
    push(32'd8, W2);
    rst = 1'b0;
    step(6);
    total++;
    if (halted !== 1'b1 || if_valid !== 1'b0) begin
      bad++;
      $display("FAIL straight_halt: got halted=%b v=%b, expected 1/0", halted, if_valid);
    end
    total++;
    if (rom_addr !== 5'd3 || fetch_count !== 32'd3) begin
      bad++;
      $display("FAIL straight_pc_count: got addr=%0d cnt=%0d, expected 3/3", rom_addr, fetch_count);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL straight_pending: got %0d undelivered, expected 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    do_reset();
    push(32'd0, W0);
    push(32'd4, W1);
    push(32'd8, W2);
    rst = 1'b0;
    step(2);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'd4 || if_instr !== W1 || rom_addr !== 5'd2 || fetch_count !== 32'd2) begin
        bad++;
        $display("FAIL stall_hold: got v=%b pc=%h instr=%h addr=%0d cnt=%0d, expected 1/4/%h/2/2",
                 if_valid, if_pc, if_instr, rom_addr, fetch_count, W1);
      end
    end
    stall = 1'b0;
    step();
    total++;
    if (if_pc !== 32'd8 || fetch_count !== 32'd3) begin
      bad++;
      $display("FAIL stall_resume: got pc=%h cnt=%0d, expected 8/3", if_pc, fetch_count);
    end
    step(2);
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL stall_pending: got %0d undelivered, expected 0", exp_q.size());
    end
  endtask

  task automatic test_redirect();
    do_reset();
    push(32'd0, W0);
    push(32'd4, W1);
    push(32'd4, W1);
    push(32'd8, W2);
    rst = 1'b0;
    step(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0006;
    step();
    redirect_valid = 1'b0;
    total++;
    if (if_valid !== 1'b0 || rom_addr !== 5'd1) begin
      bad++;
      $display("FAIL redirect_bubble: got v=%b addr=%0d, expected 0/1", if_valid, rom_addr);
    end
    total++;
    if (if_pc !== 32'd4 || if_instr !== W1) begin
      bad++;
      $display("FAIL redirect_hold: got pc=%h instr=%h, expected 4/%h", if_pc, if_instr, W1);
    end
    step(4);
    total++;
    if (halted !== 1'b1 || fetch_count !== 32'd4 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL redirect_end: got halted=%b cnt=%0d pending=%0d, expected 1/4/0",
               halted, fetch_count, exp_q.size());
    end
  endtask

  task automatic test_halt_exit();
    // Continues from the halted state left by test_redirect.
    push(32'd0, W0);
    push(32'd4, W1);
    push(32'd8, W2);
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    total++;
    if (halted !== 1'b0 || if_valid !== 1'b0 || rom_addr !== 5'd0) begin
      bad++;
      $display("FAIL halt_exit: got halted=%b v=%b addr=%0d, expected 0/0/0", halted, if_valid, rom_addr);
    end
    step(5);
    total++;
    if (halted !== 1'b1 || fetch_count !== 32'd7 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL halt_refetch: got halted=%b cnt=%0d pending=%0d, expected 1/7/0",
               halted, fetch_count, exp_q.size());
    end
  endtask

  task automatic test_out_of_range();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0080;
    step();
    redirect_valid = 1'b0;
    total++;
    if (halted !== 1'b0 || rom_addr !== 5'd0) begin
      bad++;
      $display("FAIL oor_redirect: got halted=%b addr=%0d, expected 0/0", halted, rom_addr);
    end
    step(3);
    total++;
    if (halted !== 1'b1 || if_valid !== 1'b0 || fetch_count !== 32'd7) begin
      bad++;
      $display("FAIL oor_halt: got halted=%b v=%b cnt=%0d, expected 1/0/7", halted, if_valid, fetch_count);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    push(32'd0, W0);
    push(32'd4, W1);
    rst = 1'b0;
    step(2);
    stall = 1'b1;
    rst   = 1'b1;
    step();
    total++;
    if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h0) begin
      bad++;
      $display("FAIL midrst_ifid: got v=%b pc=%h instr=%h, expected 0/0/%h", if_valid, if_pc, if_instr, NOP);
    end
    total++;
    if (fetch_count !== 32'h0 || rom_addr !== 5'd0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state: got cnt=%0d addr=%0d halted=%b, expected 0/0/0", fetch_count, rom_addr, halted);
    end
    stall = 1'b0;
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL midrst_pending: got %0d undelivered, expected 0", exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) rom[i] = NOP;
    rom[0] = W0;
    rom[1] = W1;
    rom[2] = W2;
    rom[3] = HALT;

    test_reset();
    test_straight_line();
    test_stall();
    test_redirect();
    test_halt_exit();
    test_out_of_range();
    test_reset_mid_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
